image_loader: RTL and testbench
===============================

IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 Parameter N_PIX, default 25, number of pixels per frame (5x5 binary image, row-major).
REQ-002 Parameter ADDR_W, default 5, address width; SHALL satisfy 2**ADDR_W >= N_PIX.
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  reset; synchronous, active-low.
REQ-005 i_valid  input  1  upstream pixel beat valid.
REQ-006 i_sof  input  1  start-of-frame marker, qualified by i_valid; marks pixel 0.
REQ-007 i_data  input  1  pixel bit (parity bit on the parity beat when LOADER_PARITY_EN is defined).
REQ-008 o_ready  output  1  loader accepts a beat when high.
REQ-009 i_release  input  1  consumer frees the buffer.
REQ-010 i_addr  input  ADDR_W  read address.
REQ-011 o_pixel  output  1  pixel at i_addr; combinational read.
REQ-012 o_image_valid  output  1  level; buffer holds a complete, accepted frame.
REQ-013 o_frame_done  output  1  single-cycle pulse on frame acceptance.
REQ-014 o_err  output  1  sticky error flag (parity or framing).

Function
REQ-015 Beat transfer SHALL occur on a cycle with i_valid && o_ready.
REQ-016 FSM states SHALL be IDLE, LOAD, CHECK, DONE.
REQ-017 IDLE: o_ready=1; beats without i_sof dropped; beat with i_sof writes i_data to address 0, count=1, go LOAD.
REQ-018 LOAD: o_ready=1; each beat writes i_data to address count, count increments; beat writing address N_PIX-1 moves to CHECK (parity on) or DONE (parity off).
REQ-019 A beat with i_sof in LOAD SHALL restart the frame: write address 0, count=1, set o_err (truncated frame).
REQ-020 DONE entry: o_image_valid=1 and o_frame_done pulsed for exactly the entry cycle; o_ready=0 while in DONE.
REQ-021 DONE: i_release high for one cycle SHALL clear o_image_valid and return to IDLE on the next edge; i_release in other states ignored.
REQ-022 o_pixel SHALL equal stored bit at i_addr in every state; i_addr >= N_PIX SHALL read 0.
REQ-023 Buffer contents SHALL persist after release until overwritten by a new frame.
REQ-024 Counter SHALL never exceed N_PIX-1; no wrap-around writes past the frame.
REQ-025 o_err SHALL clear only on reset or on the i_sof beat accepted in IDLE.

Reset
REQ-026 With i_rst_n low at a rising edge: state=IDLE, count=0, o_image_valid=0, o_frame_done=0, o_err=0; o_ready=1 from the following cycle.
REQ-027 Reset mid-LOAD or in DONE SHALL discard the partial or held frame flags; buffer bit contents need not be cleared.

Configuration
REQ-028 Macro LOADER_PARITY_EN defined: after pixel N_PIX-1, CHECK state (o_ready=1) accepts one parity beat; i_data SHALL equal the XOR of all N_PIX pixels (even parity); match -> DONE; mismatch -> o_err=1, IDLE, no o_frame_done, o_image_valid stays 0; i_sof on the parity beat is treated as a new frame as in REQ-019.
REQ-029 Macro undefined: CHECK state absent; frame is N_PIX beats; o_err set only by REQ-019.

Verification
REQ-030 Reset, then 25 beats of alternating 1,0,1,... with i_sof on first -> o_frame_done pulse once, o_image_valid=1, o_pixel=1 at i_addr=0,12,24, 0 at 1,23; o_pixel=0 at i_addr=25 and 31.
REQ-031 In DONE, hold i_valid=1 for 10 cycles -> o_ready=0, buffer unchanged; pulse i_release -> o_image_valid=0, o_ready=1 next cycle.
REQ-032 Send 10 beats, then i_sof beat -> o_err=1, count restarts; complete 25 more beats -> o_image_valid=1 with new data.
REQ-033 Beats without i_sof in IDLE (5 beats of 1) -> no writes, state stays IDLE, o_err=0.
REQ-034 Assert i_rst_n=0 for one cycle after 12 beats -> o_image_valid=0, o_err=0, next frame loads normally.
REQ-035 With LOADER_PARITY_EN: checkerboard frame (13 ones) plus parity 1 -> accepted; same frame plus parity 0 -> o_err=1, no o_frame_done, back to IDLE.

Source files
------------

// File: rtl/image_loader_if.sv
// Pixel-stream, release and read-port signals of the image loader.
// The bench drives the master side; the loader sits on the slave side.
interface image_loader_if #(
    parameter int ADDR_W = 5
);
    logic              i_valid;
    logic              i_sof;
    logic              i_data;
    logic              o_ready;
    logic              i_release;
    logic [ADDR_W-1:0] i_addr;
    logic              o_pixel;
    logic              o_image_valid;
    logic              o_frame_done;
    logic              o_err;

    modport master (
        output i_valid, i_sof, i_data, i_release, i_addr,
        input  o_ready, o_pixel, o_image_valid, o_frame_done, o_err
    );

    modport slave (
        input  i_valid, i_sof, i_data, i_release, i_addr,
        output o_ready, o_pixel, o_image_valid, o_frame_done, o_err
    );
endinterface

// File: rtl/image_loader.sv
// Loads one N_PIX-bit binary frame from a beat stream and holds it for a consumer.
// Optional trailing even-parity beat when LOADER_PARITY_EN is defined.
module image_loader #(
    parameter int N_PIX  = 25,
    parameter int ADDR_W = 5
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    image_loader_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_PIX - 1);

    state_t            state, state_d;
    logic [N_PIX-1:0]  mem;
    logic [ADDR_W-1:0] count, count_d;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;
    logic              err, err_set, err_clr;
    logic              frame_done, done_d;
    logic              beat;

    assign bus.o_ready       = (state != DONE);
    assign bus.o_image_valid = (state == DONE);
    assign bus.o_frame_done  = frame_done;
    assign bus.o_err         = err;
    assign beat              = bus.i_valid && bus.o_ready;

    // Addresses beyond the frame read as zero rather than aliasing.
    assign bus.o_pixel = (32'(bus.i_addr) < N_PIX) ? mem[bus.i_addr] : 1'b0;

    always_comb begin
        state_d = state;
        count_d = count;
        wr_en   = 1'b0;
        wr_addr = count;
        err_set = 1'b0;
        err_clr = 1'b0;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (beat && bus.i_sof) begin
                    wr_en   = 1'b1;
                    wr_addr = '0;
                    count_d = ADDR_W'(1);
                    err_clr = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (beat) begin
                    wr_en = 1'b1;
                    if (bus.i_sof) begin
                        // Truncated frame: restart from pixel 0 and flag it.
                        wr_addr = '0;
                        count_d = ADDR_W'(1);
                        err_set = 1'b1;
                    end else if (count == LAST) begin
                        count_d = '0;
`ifdef LOADER_PARITY_EN
                        state_d = CHECK;
`else
                        state_d = DONE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        count_d = count + 1'b1;
                    end
                end
            end
            CHECK: begin
`ifdef LOADER_PARITY_EN
                if (beat) begin
                    if (bus.i_sof) begin
                        wr_en   = 1'b1;
                        wr_addr = '0;
                        count_d = ADDR_W'(1);
                        err_set = 1'b1;
                        state_d = LOAD;
                    end else if (bus.i_data == ^mem) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        err_set = 1'b1;
                        state_d = IDLE;
                    end
                end
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                if (bus.i_release) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            count      <= '0;
            err        <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            count      <= count_d;
            frame_done <= done_d;
            if (err_set)      err <= 1'b1;
            else if (err_clr) err <= 1'b0;
        end
    end

    // Pixel store is not reset; a held frame survives release until overwritten.
    always_ff @(posedge i_clk) begin
        if (wr_en && i_rst_n) mem[wr_addr] <= bus.i_data;
    end
endmodule

// File: tb/tb_image_loader.sv
// Directed bench for image_loader with a frame-level reference model checked every cycle.
module tb_image_loader;
    localparam int N = 25;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    image_loader_if #(.ADDR_W(5)) bus ();

    image_loader #(.N_PIX(N), .ADDR_W(5)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int dut_done = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame position (-1 = waiting for sof), parity pending, frame held.
    bit m_mem [N];
    int m_pos = -1;
    bit m_chk = 0;
    bit m_hold = 0;
    bit m_err = 0;
    bit m_pulse = 0;
    bit started = 0;

    function automatic bit frame_parity();
        bit p = 0;
        for (int i = 0; i < N; i++) p ^= m_mem[i];
        return p;
    endfunction

    always @(posedge clk) begin
        started = 1;
        m_pulse = 0;
        if (!rst_n) begin
            m_pos = -1; m_chk = 0; m_hold = 0; m_err = 0;
        end else if (m_hold) begin
            if (bus.i_release) m_hold = 0;
        end else if (bus.i_valid) begin
            if (bus.i_sof) begin
                m_err = (m_pos >= 0 || m_chk);
                m_mem[0] = bus.i_data;
                m_pos = 1;
                m_chk = 0;
            end else if (m_chk) begin
                m_chk = 0;
                if (bus.i_data == frame_parity()) begin m_hold = 1; m_pulse = 1; end
                else m_err = 1;
            end else if (m_pos >= 0) begin
                m_mem[m_pos] = bus.i_data;
                m_pos++;
                if (m_pos == N) begin
                    m_pos = -1;
`ifdef LOADER_PARITY_EN
                    m_chk = 1;
`else
                    m_hold = 1; m_pulse = 1;
`endif
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            bit exp_pix;
            exp_pix = (int'(bus.i_addr) < N) ? m_mem[bus.i_addr] : 1'b0;
            chk("ready", bus.o_ready, !m_hold);
            chk("image_valid", bus.o_image_valid, m_hold);
            chk("frame_done", bus.o_frame_done, m_pulse);
            chk("err", bus.o_err, m_err);
            chk("pixel", bus.o_pixel, exp_pix);
            if (bus.o_frame_done) dut_done++;
        end
    end

    task automatic cyc(bit v, bit s, bit d, bit rel);
        bus.i_valid = v; bus.i_sof = s; bus.i_data = d; bus.i_release = rel;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(logic [N-1:0] pat, bit par);
        for (int i = 0; i < N; i++) cyc(1'b1, i == 0, pat[i], 1'b0);
`ifdef LOADER_PARITY_EN
        cyc(1'b1, 1'b0, par, 1'b0);
`else
        if (par) begin end
`endif
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pix(int a, bit e);
        bus.i_addr = 5'(a);
        #1;
        chk($sformatf("pixel_at_%0d", a), bus.o_pixel, e);
    endtask

    logic [N-1:0] checker_pat, third_pat, ones_pat;
    int done_before;

    initial begin
        bus.i_valid = 0; bus.i_sof = 0; bus.i_data = 0; bus.i_release = 0; bus.i_addr = '0;
        for (int i = 0; i < N; i++) begin
            checker_pat[i] = (i % 2 == 0);
            third_pat[i]   = (i % 3 == 0);
            ones_pat[i]    = 1'b1;
        end
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        rst_n = 1'b1;
        #1;
        chk("reset_ready", bus.o_ready, 1);
        chk("reset_image_valid", bus.o_image_valid, 0);
        chk("reset_err", bus.o_err, 0);

        // Beats without sof are dropped in IDLE.
        for (int i = 0; i < 5; i++) cyc(1, 0, 1, 0);
        cyc(0, 0, 0, 0);
        chk("nosof_err", bus.o_err, 0);
        chk("nosof_image_valid", bus.o_image_valid, 0);

        // Alternating frame, 13 ones -> even parity bit 1.
        done_before = dut_done;
        send_frame(checker_pat, 1'b1);
        chk("alt_done_count", dut_done - done_before, 1);
        chk("alt_image_valid", bus.o_image_valid, 1);
        pix(0, 1); pix(12, 1); pix(24, 1); pix(1, 0); pix(23, 0);
        pix(25, 0); pix(31, 0);

        // Held frame ignores further beats.
        bus.i_addr = 5'd0;
        for (int i = 0; i < 10; i++) cyc(1, i[0], 0, 0);
        chk("hold_ready", bus.o_ready, 0);
        pix(0, 1); pix(2, 1);
        cyc(0, 0, 0, 1);
        chk("release_image_valid", bus.o_image_valid, 0);
        chk("release_ready", bus.o_ready, 1);
        pix(12, 1);

        // Truncated frame after 10 beats, then a full replacement frame.
        cyc(1, 1, 0, 0);
        for (int i = 0; i < 9; i++) cyc(1, 0, 0, 0);
        cyc(1, 1, third_pat[0], 0);
        chk("trunc_err", bus.o_err, 1);
        for (int i = 1; i < N; i++) cyc(1, 0, third_pat[i], 0);
`ifdef LOADER_PARITY_EN
        cyc(1, 0, 1, 0);
`endif
        cyc(0, 0, 0, 0);
        chk("trunc_image_valid", bus.o_image_valid, 1);
        chk("trunc_err_sticky", bus.o_err, 1);
        pix(3, 1); pix(1, 0); pix(2, 0); pix(24, 1);
        cyc(0, 0, 0, 1);

        // Reset mid-load after 12 beats.
        cyc(1, 1, 1, 0);
        for (int i = 0; i < 11; i++) cyc(1, 0, 1, 0);
        rst_n = 1'b0;
        cyc(0, 0, 0, 0);
        rst_n = 1'b1;
        #1;
        chk("midrst_image_valid", bus.o_image_valid, 0);
        chk("midrst_err", bus.o_err, 0);
        send_frame(ones_pat, 1'b1);
        chk("afterrst_image_valid", bus.o_image_valid, 1);
        pix(12, 1); pix(20, 1);
        cyc(0, 0, 0, 1);

`ifdef LOADER_PARITY_EN
        // Wrong parity bit is rejected without a done pulse.
        done_before = dut_done;
        send_frame(checker_pat, 1'b0);
        chk("badpar_err", bus.o_err, 1);
        chk("badpar_image_valid", bus.o_image_valid, 0);
        chk("badpar_done_count", dut_done - done_before, 0);
        chk("badpar_ready", bus.o_ready, 1);
`endif
        cyc(0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
